// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions for the in-order core: default
// control/payload widths per stage boundary and the ID/EX control layout.
package pipe_pkg;

  // IF/ID: control is just a predicted-taken bit and a fault bit; payload is pc + instr.
  localparam int IF_ID_CTRL_W  = 2;
  localparam int IF_ID_DATA_W  = 64;
  // ID/EX: decoded control (see id_ex_ctrl_t, two spare bits); operands, imm, funct, regs.
  localparam int ID_EX_CTRL_W  = 10;
  localparam int ID_EX_DATA_W  = 128;
  // EX/MEM: memory + writeback control; alu result, store data, rd.
  localparam int EX_MEM_CTRL_W = 5;
  localparam int EX_MEM_DATA_W = 72;
  // MEM/WB: writeback control; result and rd.
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 40;

  // ID/EX control field layout (msb first). Occupies the low 8 bits of ID_EX_CTRL_W.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
  } id_ex_ctrl_t;

  localparam int ID_EX_CTRL_USED_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage register: kill > hold > bubble > load priority mux
// in front of valid/ctrl/data flops. ctrl is kept zero whenever valid is zero.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  input  logic [CTRL_W-1:0] load_ctrl_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              hold_i,
  input  logic              kill_i,
  input  logic              bubble_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next-state priority mux; data is only ever replaced by a real load.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (hold_i) begin
      valid_d = valid_q;
    end else if (bubble_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = load_valid_i;
      ctrl_d  = load_valid_i ? load_ctrl_i : '0;
      data_d  = load_data_i;
    end
  end

  // Stage flops, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH pipeline stage registers with per-stage
// stall/flush, upstream stall propagation and automatic bubble insertion.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DEPTH-1:0]  stall_i,
  input  logic [DEPTH-1:0]  flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DEPTH-1:0]  valid_vec_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  logic [DEPTH-1:0]             hold;
  logic [DEPTH-1:0]             bubble;
  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             up_vld;
  logic [DEPTH-1:0][CTRL_W-1:0] up_ctrl;
  logic [DEPTH-1:0][DATA_W-1:0] up_data;

  // hold[k] is the OR of stall_i[DEPTH-1:k]: any downstream stall freezes stage k.
  always_comb begin
    hold = '0;
    for (int k = 0; k < DEPTH; k++) hold[k] = |(stall_i >> k);
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_vld[k]  = valid_i;
      assign up_ctrl[k] = ctrl_i;
      assign up_data[k] = data_i;
      assign bubble[k]  = 1'b0;
    end else begin : g_body
      assign up_vld[k]  = vld_q[k-1];
      assign up_ctrl[k] = ctrl_q[k-1];
      assign up_data[k] = data_q[k-1];
      // Upstream frozen while this stage advances: drain into an empty slot.
      assign bubble[k]  = hold[k-1] & ~hold[k];
    end

    pipe_stage_cell #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_cell (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_valid_i (up_vld[k]),
      .load_ctrl_i  (up_ctrl[k]),
      .load_data_i  (up_data[k]),
      .hold_i       (hold[k]),
      .kill_i       (flush_i[k]),
      .bubble_i     (bubble[k]),
      .valid_o      (vld_q[k]),
      .ctrl_o       (ctrl_q[k]),
      .data_o       (data_q[k])
    );
  end

  assign ready_o     = ~hold[0];
  assign valid_o     = vld_q[DEPTH-1];
  assign ctrl_o      = ctrl_q[DEPTH-1];
  assign data_o      = data_q[DEPTH-1];
  assign valid_vec_o = vld_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;
  logic        any_bubble;

  // A bubble overridden by a flush on the same stage is not counted as inserted.
  assign any_bubble = |(bubble & ~flush_i);

  // Saturating perf counters: input-stall cycles and bubble-insert cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hold[0] && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (any_bubble && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain at DEPTH 3, 2 and 1.
module tb_pipe_stage_chain;

  localparam int CW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=3 instance
  logic [2:0]    st3 = '0, fl3 = '0, vv3;
  logic          v3 = 1'b0, r3, vo3;
  logic [CW-1:0] c3 = '0, co3;
  logic [DW-1:0] d3 = '0, do3;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   sc3, bc3, sc2, bc2, sc1, bc1;
`endif

  // DEPTH=2 instance
  logic [1:0]    st2 = '0, fl2 = '0, vv2;
  logic          v2 = 1'b0, r2, vo2;
  logic [CW-1:0] c2 = '0, co2;
  logic [DW-1:0] d2 = '0, do2;

  // DEPTH=1 instance
  logic [0:0]    st1 = '0, fl1 = '0, vv1;
  logic          v1 = 1'b0, r1, vo1;
  logic [CW-1:0] c1 = '0, co1;
  logic [DW-1:0] d1 = '0, do1;

  pipe_stage_chain #(.DEPTH(3), .CTRL_W(CW), .DATA_W(DW)) u3 (
    .clk_i(clk), .rst_i(rst), .stall_i(st3), .flush_i(fl3), .valid_i(v3),
    .ctrl_i(c3), .data_i(d3), .ready_o(r3), .valid_o(vo3), .ctrl_o(co3),
    .data_o(do3), .valid_vec_o(vv3)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(sc3), .bubble_cnt_o(bc3)
`endif
  );

  pipe_stage_chain #(.DEPTH(2), .CTRL_W(CW), .DATA_W(DW)) u2 (
    .clk_i(clk), .rst_i(rst), .stall_i(st2), .flush_i(fl2), .valid_i(v2),
    .ctrl_i(c2), .data_i(d2), .ready_o(r2), .valid_o(vo2), .ctrl_o(co2),
    .data_o(do2), .valid_vec_o(vv2)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(sc2), .bubble_cnt_o(bc2)
`endif
  );

  pipe_stage_chain #(.DEPTH(1), .CTRL_W(CW), .DATA_W(DW)) u1 (
    .clk_i(clk), .rst_i(rst), .stall_i(st1), .flush_i(fl1), .valid_i(v1),
    .ctrl_i(c1), .data_i(d1), .ready_o(r1), .valid_o(vo1), .ctrl_o(co1),
    .data_o(do1), .valid_vec_o(vv1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(sc1), .bubble_cnt_o(bc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv3(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    v3 = v; c3 = c; d3 = d;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1;
    chk("rst_vec3",  32'(vv3), 32'h0);
    chk("rst_ctrl3", 32'(co3), 32'h0);
    chk("rst_data3", 32'(do3), 32'h0);
    chk("rst_rdy3",  32'(r3),  32'h1);
    tick(); tick();
    rst = 1'b0;

    // ---------------- DEPTH=2 throughput ----------------
    v2 = 1'b1; c2 = 10'h3A5;
    for (int i = 1; i <= 4; i++) begin
      d2 = DW'(i);
      chk("thr_rdy", 32'(r2), 32'h1);
      tick();
      if (i >= 2) begin
        chk("thr_data",  32'(do2), 32'(i - 1));
        chk("thr_valid", 32'(vo2), 32'h1);
        chk("thr_ctrl",  32'(co2), 32'h3A5);
      end
    end
    v2 = 1'b0;
    tick();
    chk("thr_data4", 32'(do2), 32'h4);
    chk("thr_ctrl4", 32'(co2), 32'h3A5);
    tick();
    chk("thr_drain_v", 32'(vo2), 32'h0);
    chk("thr_drain_c", 32'(co2), 32'h0);

    // ---------------- DEPTH=3 load-use bubble ----------------
    drv3(1'b1, 10'd1, 16'd10); tick();
    drv3(1'b1, 10'd2, 16'd20); tick();
    drv3(1'b1, 10'd3, 16'd30); tick();
    chk("lu_fill_vec",  32'(vv3), 32'h7);
    chk("lu_fill_data", 32'(do3), 32'd10);
    drv3(1'b1, 10'd4, 16'd40);
    st3 = 3'b001;
    #1;
    chk("lu_rdy_low", 32'(r3), 32'h0);
    tick();
    chk("lu_bub_vec",  32'(vv3), 32'b101);
    chk("lu_bub_data", 32'(do3), 32'd20);
    st3 = 3'b000;
    tick();
    chk("lu_gap_vec",  32'(vv3), 32'b011);
    chk("lu_gap_ctrl", 32'(co3), 32'h0);
    drv3(1'b0, 10'd0, 16'd0);
    tick();
    chk("lu_late_data", 32'(do3), 32'd30);
    chk("lu_late_ctrl", 32'(co3), 32'd3);
    chk("lu_late_vec",  32'(vv3), 32'b110);

    // ---------------- downstream stall propagation ----------------
    drv3(1'b1, 10'd5, 16'd50);
    st3 = 3'b100;
    #1;
    chk("ds_rdy0", 32'(r3), 32'h0);
    tick();
    chk("ds_vec1",  32'(vv3), 32'b110);
    chk("ds_data1", 32'(do3), 32'd30);
    chk("ds_rdy1",  32'(r3),  32'h0);
    tick();
    chk("ds_vec2",  32'(vv3), 32'b110);
    chk("ds_data2", 32'(do3), 32'd30);
    st3 = 3'b000;
    #1;
    chk("ds_rdy_back", 32'(r3), 32'h1);
    tick();
    chk("ds_d_out", 32'(do3), 32'd40);
    chk("ds_d_ctl", 32'(co3), 32'd4);
    chk("ds_vec3",  32'(vv3), 32'b101);
    drv3(1'b0, 10'd0, 16'd0);
    tick();
    chk("ds_vec4", 32'(vv3), 32'b010);
    tick();
    chk("ds_e_out", 32'(do3), 32'd50);
    chk("ds_e_ctl", 32'(co3), 32'd5);

    // ---------------- flush over stall ----------------
    drv3(1'b1, 10'd6, 16'd60); tick();
    drv3(1'b1, 10'd7, 16'd70); tick();
    drv3(1'b1, 10'd8, 16'd80); tick();
    chk("fl_fill_vec", 32'(vv3), 32'h7);
    drv3(1'b0, 10'd0, 16'd0);
    st3 = 3'b010; fl3 = 3'b010;
    tick();
    chk("fl_vec",  32'(vv3), 32'b001);
    chk("fl_vo",   32'(vo3), 32'h0);
    chk("fl_co",   32'(co3), 32'h0);
    chk("fl_do",   32'(do3), 32'd60);
    fl3 = 3'b000;
    tick();
    chk("fl_held_empty", 32'(vv3), 32'b001);
    st3 = 3'b000;
    tick();
    // flushed stage 1 kept its payload; it moves out with valid=0
    chk("fl_kept_data", 32'(do3), 32'd70);
    chk("fl_kept_vo",   32'(vo3), 32'h0);
    chk("fl_vec2",      32'(vv3), 32'b010);
    tick();
    chk("fl_h_out", 32'(do3), 32'd80);
    chk("fl_h_ctl", 32'(co3), 32'd8);

    // ---------------- asynchronous reset mid-stream ----------------
    drv3(1'b1, 10'd9,  16'd90);  tick();
    drv3(1'b1, 10'd10, 16'd100); tick();
    drv3(1'b1, 10'd11, 16'd110); tick();
    chk("ar_full", 32'(vv3), 32'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_vec",  32'(vv3), 32'h0);
    chk("ar_ctrl", 32'(co3), 32'h0);
    chk("ar_data", 32'(do3), 32'h0);
    drv3(1'b0, 10'd0, 16'd0);
    tick();
    rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    // ---------------- perf counters ----------------
    chk("pf_rst_sc", sc3, 32'h0);
    force u3.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u3.stall_cnt_q;
    st3 = 3'b001;
    tick(); tick(); tick();
    st3 = 3'b000;
    tick();
    chk("pf_stall_sat", sc3, 32'hFFFF_FFFF);
    chk("pf_bubbles",   bc3, 32'd3);
`endif

    // ---------------- DEPTH=1 stall/flush register ----------------
    v1 = 1'b1; c1 = 10'h155; d1 = 16'hABCD;
    tick();
    chk("d1_v",  32'(vo1), 32'h1);
    chk("d1_c",  32'(co1), 32'h155);
    chk("d1_d",  32'(do1), 32'hABCD);
    c1 = 10'h0AA; d1 = 16'h1234; st1 = 1'b1;
    #1;
    chk("d1_rdy", 32'(r1), 32'h0);
    tick();
    chk("d1_hold_d", 32'(do1), 32'hABCD);
    chk("d1_hold_c", 32'(co1), 32'h155);
    fl1 = 1'b1;
    tick();
    chk("d1_fl_v", 32'(vo1), 32'h0);
    chk("d1_fl_c", 32'(co1), 32'h0);
    chk("d1_fl_d", 32'(do1), 32'hABCD);
    fl1 = 1'b0; st1 = 1'b0;
    tick();
    chk("d1_load_d", 32'(do1), 32'h1234);
    chk("d1_load_c", 32'(co1), 32'h0AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
